// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the CPU MEM-stage data port and a
// slower backing data memory.
//
// The CPU stores in one cycle. Buffered stores drain to memory in push order
// over a valid/ready handshake. Loads see the youngest buffered data for their
// word. stall is raised only when a store cannot be accepted, or while a sync
// waits for the buffer to empty.
//
// Ports:
//   clock, reset          system clock; asynchronous active-low reset
//   cpu_addr, cpu_wdata   MEM-stage byte address and store data
//   cpu_write             store request (low: cpu_addr is a load address)
//   sync                  drain request for exception entry and fences
//   cpu_rdata             load data (combinational)
//   stall                 hold the MEM stage this cycle (combinational)
//   mem_raddr, mem_rdata  backing-memory read port (mem_raddr = cpu_addr)
//   mem_waddr, mem_wdata,
//   mem_wvalid, mem_wready backing-memory write handshake, driven from the head entry
//   count                 number of occupied entries
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_write,
  input  logic                     sync,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     stall,
  output logic [ADDR_W-1:0]        mem_raddr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wvalid,
  input  logic                     mem_wready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r, tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              mem_wvalid_r;
  logic [ADDR_W-1:0] mem_waddr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              full_s, empty_s, stall_s, push_s, pop_s;
  logic [PTR_W-1:0]  head_next_s, tail_next_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [ADDR_W-1:0] waddr_next_s;
  logic [DATA_W-1:0] wdata_next_s;
  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_data_s;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == CNT_W'(0));
  // stall deliberately ignores mem_wready: a full buffer refuses a push even
  // when a pop happens on the same edge.
  assign stall_s = (cpu_write & full_s) | (sync & ~empty_s);
  assign push_s  = cpu_write & ~stall_s;
  // mem_wvalid_r always mirrors ~empty, so it doubles as the pop qualifier.
  assign pop_s   = mem_wvalid_r & mem_wready;

  assign stall      = stall_s;
  assign mem_raddr  = cpu_addr;
  assign mem_wvalid = mem_wvalid_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign count      = count_r;

  // Next pointer and occupancy values for the coming edge.
  always_comb begin
    head_next_s  = pop_s  ? head_r + PTR_W'(1) : head_r;
    tail_next_s  = push_s ? tail_r + PTR_W'(1) : tail_r;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Head entry after the edge. If the store being pushed lands on the new
  // head slot (buffer drains to empty on this edge), bypass it straight to
  // the write port so it is visible one cycle after its push.
  always_comb begin
    if (push_s && (tail_r == head_next_s)) begin
      waddr_next_s = cpu_addr;
      wdata_next_s = cpu_wdata;
    end else begin
      waddr_next_s = addr_mem_r[head_next_s];
      wdata_next_s = data_mem_r[head_next_s];
    end
  end

  // Youngest-match forwarding: walk from head (oldest) toward tail, so a
  // later match overwrites an earlier one. Byte offset bits are ignored.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx_v;
      idx_v = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) &&
          (addr_mem_r[idx_v][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_mem_r[idx_v];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Load data mux: forwarded data on a hit, otherwise memory read data.
  always_comb begin
    if (!cpu_write && fwd_hit_s) begin
      cpu_rdata = fwd_data_s;
    end else begin
      cpu_rdata = mem_rdata;
    end
  end

  // Entry storage: capture accepted stores at tail.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      addr_mem_r[tail_r] <= cpu_addr;
      data_mem_r[tail_r] <= cpu_wdata;
    end
  end

  // Pointers, occupancy and the registered drain port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      mem_wvalid_r <= 1'b0;
      mem_waddr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
    end else begin
      head_r       <= head_next_s;
      tail_r       <= tail_next_s;
      count_r      <= count_next_s;
      mem_wvalid_r <= (count_next_s != CNT_W'(0));
      mem_waddr_r  <= waddr_next_s;
      mem_wdata_r  <= wdata_next_s;
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipelined CPU's MEM-stage data port and a slower backing data memory.
- Accepts CPU stores in one cycle and drains them in order to memory over a valid/ready handshake.
- Forwards buffered data to CPU loads so reads always see the youngest value.
- Asserts stall only when a store cannot be accepted, or when a sync is pending.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
DATA_W, 32, data width in bits
ADDR_W, 32, byte address width in bits

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
cpu_addr  input  ADDR_W  MEM-stage byte address (ALU result)
cpu_wdata  input  DATA_W  MEM-stage store data
cpu_write  input  1  store request; when low, cpu_addr is a load address
sync  input  1  drain request; used for exception entry and fences
cpu_rdata  output  DATA_W  load data, combinational
stall  output  1  CPU must hold the MEM stage this cycle
mem_raddr  output  ADDR_W  backing-memory read address; always equals cpu_addr
mem_rdata  input  DATA_W  backing-memory read data, combinational
mem_waddr  output  ADDR_W  head entry address
mem_wdata  output  DATA_W  head entry data
mem_wvalid  output  1  head entry valid
mem_wready  input  1  backing memory accepts the write
count  output  clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data}, with head pointer, tail pointer and count.
- Pointers wrap modulo DEPTH. full = (count == DEPTH). empty = (count == 0).
- Reset (reset low, asynchronous):
  - head, tail and count go to 0; all entry fields clear to 0.
  - mem_wvalid=0, mem_waddr=0, mem_wdata=0 immediately.
  - Reset mid-drain discards all buffered stores; the in-flight write is abandoned.
- stall = (cpu_write & full) | (sync & ~empty). It is combinational and must not depend on mem_wready.
- Push: on a rising edge with cpu_write=1 and stall=0, write {cpu_addr, cpu_wdata} at tail, then tail+1.
  - A store that arrives while stall=1 is not captured; the CPU re-presents it.
- Drain:
  - mem_wvalid = ~empty; mem_waddr and mem_wdata are driven from the head entry.
  - These outputs stay stable while mem_wvalid=1 and mem_wready=0.
  - On a rising edge with mem_wvalid & mem_wready, head advances by 1.
  - Writes leave strictly in push order.
- Simultaneous push and pop in one edge: both occur and count is unchanged.
  - When full, a push is refused even if a pop happens on the same edge. The store is accepted on the next edge.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Load forwarding (cpu_write=0):
  - Matching compares word addresses, cpu_addr[ADDR_W-1:2] against entry addr[ADDR_W-1:2]. Byte offset bits [1:0] are ignored.
  - On a match, cpu_rdata = data of the youngest valid entry that matches (nearest to tail). Otherwise cpu_rdata = mem_rdata.
  - The head entry counts as valid until its handshake edge completes.
  - Forwarding is combinational, zero added latency.
- cpu_rdata during a store cycle (cpu_write=1) is don't-care; drive mem_rdata.
- sync: stall stays high while sync=1 and entries remain.
  - Stall drops in the cycle count becomes 0.
  - sync with the buffer empty produces no stall.
- Latency: a store becomes visible on mem_wvalid one cycle after its push edge, provided it is at the head.

Test Plan:
- Reset: drive reset low mid-operation with 2 entries buffered and mem_wready=0 -> mem_wvalid=0 and count=0 immediately; cpu_rdata passes mem_rdata after release.
- Single store: write 0x100<-0xDEADBEEF with mem_wready=0 -> next cycle mem_wvalid=1, mem_waddr=0x100, mem_wdata=0xDEADBEEF, count=1. Load 0x102 with mem_rdata=0 -> cpu_rdata=0xDEADBEEF. After a one-cycle wready pulse -> count=0 and the load returns mem_rdata.
- Youngest-match forwarding: store 0x200<-1, then 0x200<-2, wready=0 -> load 0x200 returns 2. Release wready -> drain order is data 1 then 2.
- Full: DEPTH=4, wready=0, push 4 stores -> count=4. Fifth cpu_write -> stall=1 and no capture. Pulse wready -> count=3, stall=0, fifth store captured on the next edge -> count=4.
- Wrap and concurrency: wready=1 continuously, push 10 stores with addresses 0x0..0x24 on consecutive cycles -> count stays at 1, and the memory sees all 10 writes in order with no loss across pointer wrap.
- sync: 3 entries buffered, wready=1, sync=1 -> stall high for exactly 3 cycles, then 0 with count=0. sync with the buffer empty -> stall=0.
